tipi_rpi_shift_bridge: RTL and testbench
========================================

# tipi_rpi_shift_bridge

Parametrised, single-clock serial register bridge between the Raspberry Pi and the TIPI TI-side logic. It replaces the per-register shift chains clocked directly by Pi clock pins with NUM_CH channels of WIDTH-bit registers. All Pi pins are oversampled on `clk`, and frames are validated by bit count. Each channel also shifts a TI-side value back to the Pi in the same frame. It sits between the Pi GPIO header pins and the TI-facing register and bus-transmitter logic.

## Interface
- WIDTH, 8: bits per channel register.
- NUM_CH, 2: number of channels; channel 0 = data, channel 1 = control.
- SYNC_STAGES, 2: synchronizer depth for Pi inputs, minimum 2.
- SEL_W, derived as max(1, clog2(NUM_CH)): channel-select width.
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rpi_sclk  in  1  Pi shift clock, asynchronous.
- rpi_sdata  in  1  Pi serial data, MSB first.
- rpi_le  in  1  Pi latch enable. High = idle or commit; low = frame in progress.
- rpi_sel  in  SEL_W  Pi channel select, asynchronous.
- rpi_sdout  out  1  serial data to the Pi, MSB first.
- tx_data  in  NUM_CH*WIDTH  TI-side values offered to the Pi. Channel n occupies bits [n*WIDTH +: WIDTH].
- rx_data  out  NUM_CH*WIDTH  committed Pi-written registers, same packing as tx_data.
- rx_strobe  out  NUM_CH  one-cycle pulse per channel on commit.
- frame_err  out  1  sticky error flag.
- err_clr  in  1  synchronous clear of frame_err.

## Operation
- All of rpi_sclk, rpi_sdata, rpi_le and rpi_sel pass through SYNC_STAGES flops. Edge detection uses the last synchronized stage against one extra delay flop.
- Two states: IDLE and SHIFT. Reset state is IDLE.
- IDLE -> SHIFT on a falling edge of synced le. On this transition:
  - the synced rpi_sel is captured into sel_q and held for the whole frame;
  - bit_cnt is cleared to 0;
  - tx_sr is loaded from tx_data[sel_q].
- In SHIFT, on each rising edge of synced sclk:
  - rx_sr <= {rx_sr[WIDTH-2:0], sdata_sync};
  - tx_sr shifts left with 0 filled in;
  - bit_cnt increments and saturates at WIDTH+1.
- SHIFT -> IDLE on a rising edge of synced le:
  - bit_cnt == WIDTH: rx_data[sel_q] <= rx_sr and rx_strobe[sel_q] pulses.
  - bit_cnt != WIDTH (short or overrun): no register update, no strobe, frame_err is set.
- sel_q >= NUM_CH (non-power-of-2 NUM_CH): the frame is consumed, tx_sr shifts zeros out, commit is suppressed, and frame_err is set.
- sclk edges seen in IDLE are ignored.
- rpi_sdout = tx_sr[WIDTH-1] in SHIFT and 0 in IDLE.
- frame_err: set takes priority over err_clr when both occur in the same cycle.
- Reset values:
  - rx_data = 0, rx_strobe = 0, frame_err = 0, rpi_sdout = 0;
  - all synchronizer flops = 0, except the le chain, which resets to 1 so that reset release is not seen as a frame start;
  - state = IDLE.
- Reset asserted mid-frame abandons the frame. No commit and no error are produced after release.
- tx_data is snapshotted only at frame start. Changes to tx_data during a frame do not affect rpi_sdout.

## Timing
- Pi constraints:
  - sclk high and low phases each at least SYNC_STAGES+2 clk cycles;
  - sdata and sel stable from at least 1 clk before the sclk or le edge at the pin until SYNC_STAGES+1 clk after it;
  - le high for at least SYNC_STAGES+2 clk cycles between frames.
- Edge detect latency: SYNC_STAGES+1 clk from the pin edge to internal action.
- Commit latency: rx_data and rx_strobe are registered and valid SYNC_STAGES+2 clk after the le rising edge at the pin. rx_strobe is high for exactly one cycle.
- rpi_sdout updates SYNC_STAGES+2 clk after the le falling edge or sclk rising edge. The Pi samples it just before its next sclk rising edge, i.e. bit k is presented after edge k.
- Throughput: one commit per frame; the limit is set by the Pi pacing above.

## Structure
- Package tipi_pkg holds the WIDTH and NUM_CH defaults, the SEL_W derivation function (clog2 with a minimum of 1), and the IDLE/SHIFT state enum.
- One sub-module, tipi_sync: a SYNC_STAGES-deep single-bit synchronizer with a parameterised reset value.
  - Instantiated once per bit for sclk, sdata, le and each sel bit.
  - The le instance uses reset value 1.
- Core FSM, shift registers and commit logic stay in the top module.

## Test plan
- Data channel write: sel=0, shift 0xA5 MSB first, raise le -> rx_data[7:0]=0xA5, rx_strobe=2'b01 for one cycle, frame_err=0.
- Control channel read-back: tx_data[15:8]=0x3C, sel=1, shift 8 bits of 0x00 -> rpi_sdout sequence 0,0,1,1,1,1,0,0 and rx_data[15:8]=0x00 committed.
- Short frame: sel=0, 7 clocks, then le high -> rx_data unchanged, no strobe, frame_err=1. Pulse err_clr -> frame_err=0.
- Overrun frame: 9 clocks -> no commit, frame_err=1. err_clr held in the same cycle as the error -> frame_err stays 1.
- Sel and tx_data changed mid-frame: sel 0->1 and tx_data[7:0] 0x11->0xFF after bit 3 -> commit lands in channel 0 only, and rpi_sdout continues the 0x11 pattern.
- Reset mid-frame: assert rst_n low after 4 bits, release with le low, then raise le -> no strobe, frame_err=0, all rx_data=0.

Source files
------------

// File: rtl/tipi_pkg.sv
// Shared defaults, select-width helper and FSM state type for the TIPI Pi bridge.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package tipi_pkg;

   localparam int WIDTH_DEF  = 8;
   localparam int NUM_CH_DEF = 2;

   // Channel-select width: clog2 of the channel count, never below one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/tipi_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
// Latency: STAGES clk cycles from input to output.
// Backpressure: none; free-running sampler.
module tipi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tipi_rpi_shift_bridge.sv
// Oversampled Pi serial register bridge: NUM_CH WIDTH-bit write channels with read-back shift-out.
// Latency: pin edge to internal action SYNC_STAGES+1 clk; commit/sdout registered one clk later.
// Backpressure: none; the Pi paces frames, malformed frames are dropped and flagged in frame_err.
module tipi_rpi_shift_bridge
   import tipi_pkg::*;
#(
   parameter  int WIDTH       = WIDTH_DEF,
   parameter  int NUM_CH      = NUM_CH_DEF,
   parameter  int SYNC_STAGES = 2,
   localparam int SEL_W       = sel_width(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rpi_sclk,
   input  logic                    rpi_sdata,
   input  logic                    rpi_le,
   input  logic [SEL_W-1:0]        rpi_sel,
   output logic                    rpi_sdout,
   input  logic [NUM_CH*WIDTH-1:0] tx_data,
   output logic [NUM_CH*WIDTH-1:0] rx_data,
   output logic [NUM_CH-1:0]       rx_strobe,
   output logic                    frame_err,
   input  logic                    err_clr
);

   localparam int               CNT_W    = $clog2(WIDTH + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

   // Synchronized Pi pins
   logic             sclk_s;
   logic             sdata_s;
   logic             le_s;
   logic [SEL_W-1:0] sel_s;

   tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d_i(rpi_sclk), .q_o(sclk_s)
   );

   tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
      .clk(clk), .rst_n(rst_n), .d_i(rpi_sdata), .q_o(sdata_s)
   );

   // le idles high, so its chain resets high to keep reset release from looking like a frame start.
   tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
      .clk(clk), .rst_n(rst_n), .d_i(rpi_le), .q_o(le_s)
   );

   for (genvar i = 0; i < SEL_W; i++) begin : g_sel_sync
      tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sel (
         .clk(clk), .rst_n(rst_n), .d_i(rpi_sel[i]), .q_o(sel_s[i])
      );
   end

   // Edge detection and start-up arming
   logic                   sclk_dly_q;
   logic                   le_dly_q;
   logic [SYNC_STAGES-1:0] flush_q;
   logic                   armed_q;

   // Delay flops for edge detection; frames may only start once le has been seen high after reset.
   // flush_q marks when the le chain holds real pin samples instead of its reset value, so a reset
   // released while le is low (abandoned frame) is not mistaken for a new frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_dly_q <= 1'b0;
         le_dly_q   <= 1'b1;
         flush_q    <= '0;
         armed_q    <= 1'b0;
      end else begin
         sclk_dly_q <= sclk_s;
         le_dly_q   <= le_s;
         flush_q    <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         armed_q    <= armed_q | (flush_q[SYNC_STAGES-1] & le_s);
      end
   end

   logic sclk_rise;
   logic le_fall;
   logic le_rise;

   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign le_fall   = ~le_s & le_dly_q & armed_q;
   assign le_rise   = le_s & ~le_dly_q;

   // Frame state
   state_t                   state_q,     state_d;
   logic [SEL_W-1:0]         sel_q,       sel_d;
   logic [CNT_W-1:0]         bit_cnt_q,   bit_cnt_d;
   logic [WIDTH-1:0]         tx_sr_q,     tx_sr_d;
   logic [WIDTH-1:0]         rx_sr_q,     rx_sr_d;
   logic [NUM_CH*WIDTH-1:0]  rx_data_q,   rx_data_d;
   logic [NUM_CH-1:0]        rx_strobe_q, rx_strobe_d;
   logic                     frame_err_q, frame_err_d;

   // Channel decode of the frame's latched select, and the TI value to snapshot at frame start.
   logic [NUM_CH-1:0] ch_hit;
   logic              sel_valid;
   logic [WIDTH-1:0]  tx_load;

   // Decode channel hits; an out-of-range select hits nothing and loads zeros for shift-out.
   always_comb begin
      ch_hit  = '0;
      tx_load = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         ch_hit[n] = (sel_q == SEL_W'(n));
         if (sel_s == SEL_W'(n)) begin
            tx_load = tx_data[n*WIDTH +: WIDTH];
         end
      end
      sel_valid = |ch_hit;
   end

   // Next-state logic: frame start, bit shifting, and commit/error on frame end.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      bit_cnt_d   = bit_cnt_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      rx_data_d   = rx_data_q;
      rx_strobe_d = '0;
      frame_err_d = frame_err_q & ~err_clr;

      case (state_q)
         ST_IDLE: begin
            if (le_fall) begin
               state_d   = ST_SHIFT;
               sel_d     = sel_s;
               bit_cnt_d = '0;
               tx_sr_d   = tx_load;
            end
         end
         ST_SHIFT: begin
            if (le_rise) begin
               state_d = ST_IDLE;
               if ((bit_cnt_q == CNT_FULL) && sel_valid) begin
                  for (int n = 0; n < NUM_CH; n++) begin
                     if (ch_hit[n]) begin
                        rx_data_d[n*WIDTH +: WIDTH] = rx_sr_q;
                        rx_strobe_d[n]              = 1'b1;
                     end
                  end
               end else begin
                  // Setting wins over a simultaneous clear.
                  frame_err_d = 1'b1;
               end
            end else if (sclk_rise) begin
               rx_sr_d = {rx_sr_q[WIDTH-2:0], sdata_s};
               tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
               if (bit_cnt_q != CNT_SAT) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         bit_cnt_q   <= '0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         rx_data_q   <= '0;
         rx_strobe_q <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         rx_data_q   <= rx_data_d;
         rx_strobe_q <= rx_strobe_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rpi_sdout = (state_q == ST_SHIFT) & tx_sr_q[WIDTH-1];
   assign rx_data   = rx_data_q;
   assign rx_strobe = rx_strobe_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tipi_rpi_shift_bridge.sv
// Directed bench for the Pi shift bridge: writes, read-back, short/overrun frames, mid-frame changes, reset.
// Latency: Pi pins driven and outputs sampled on clk falling edges with generous margins.
// Backpressure: n/a.
module tb_tipi_rpi_shift_bridge;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        rpi_sclk  = 1'b0;
   logic        rpi_sdata = 1'b0;
   logic        rpi_le    = 1'b1;
   logic [0:0]  rpi_sel   = 1'b0;
   logic        rpi_sdout;
   logic [15:0] tx_data   = 16'h0000;
   logic [15:0] rx_data;
   logic [1:0]  rx_strobe;
   logic        frame_err;
   logic        err_clr   = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   tipi_rpi_shift_bridge #(
      .WIDTH(8),
      .NUM_CH(2),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rpi_sclk(rpi_sclk),
      .rpi_sdata(rpi_sdata),
      .rpi_le(rpi_le),
      .rpi_sel(rpi_sel),
      .rpi_sdout(rpi_sdout),
      .tx_data(tx_data),
      .rx_data(rx_data),
      .rx_strobe(rx_strobe),
      .frame_err(frame_err),
      .err_clr(err_clr)
   );

   // 50 MHz clock
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Open a frame and clock nbits bits of pat (MSB first from pat[8]). rb collects the first 8 sdout
   // samples, each taken just before the sclk rise. At bit index chg_at, sel and tx_data[7:0] change.
   task automatic do_frame(input logic sel, input logic [8:0] pat, input int nbits,
                           input int chg_at, output logic [7:0] rb);
      rpi_sel = sel;
      idle(2);
      rpi_le = 1'b0;
      idle(6);
      rb = '0;
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_at) begin
            rpi_sel       = ~sel;
            tx_data[7:0]  = 8'hFF;
         end
         rpi_sdata = pat[8-i];
         idle(3);
         if (i < 8) rb[7-i] = rpi_sdout;
         rpi_sclk = 1'b1;
         idle(5);
         rpi_sclk = 1'b0;
         idle(4);
      end
   endtask

   // Raise le and watch a bounded window for strobes and any frame_err assertion.
   task automatic end_frame(output int cnt, output logic [1:0] val, output logic saw_err);
      cnt     = 0;
      val     = '0;
      saw_err = 1'b0;
      rpi_le  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rx_strobe != 2'b00) begin
            cnt++;
            val = rx_strobe;
         end
         if (frame_err) saw_err = 1'b1;
      end
      idle(2);
   endtask

   initial begin
      logic [7:0] rb;
      int         cnt;
      logic [1:0] val;
      logic       saw_err;

      // Reset state
      idle(3);
      check("rst_rx_data",   rx_data,   16'h0000);
      check("rst_rx_strobe", rx_strobe, 2'b00);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_sdout",     rpi_sdout, 1'b0);
      rst_n = 1'b1;
      idle(6);

      // Data channel write, with read-back of channel 0
      tx_data = 16'h3C96;
      do_frame(1'b0, {8'hA5, 1'b0}, 8, -1, rb);
      end_frame(cnt, val, saw_err);
      check("wr0_rx_data",   rx_data,   16'h00A5);
      check("wr0_strobe_n",  cnt,       1);
      check("wr0_strobe_ch", val,       2'b01);
      check("wr0_err",       frame_err, 1'b0);
      check("wr0_readback",  rb,        8'h96);

      // Control channel read-back while writing 0x00
      do_frame(1'b1, {8'h00, 1'b0}, 8, -1, rb);
      end_frame(cnt, val, saw_err);
      check("rd1_readback",  rb,        8'h3C);
      check("rd1_rx_data",   rx_data,   16'h00A5);
      check("rd1_strobe_n",  cnt,       1);
      check("rd1_strobe_ch", val,       2'b10);
      check("rd1_err",       frame_err, 1'b0);

      // Short frame: 7 bits
      do_frame(1'b0, {8'hFF, 1'b0}, 7, -1, rb);
      end_frame(cnt, val, saw_err);
      check("short_rx_data",  rx_data,   16'h00A5);
      check("short_strobe_n", cnt,       0);
      check("short_err",      frame_err, 1'b1);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      idle(2);
      check("short_err_clr",  frame_err, 1'b0);

      // Overrun frame: 9 bits, err_clr held across the error so it coincides with the set
      do_frame(1'b0, {8'h0F, 1'b1}, 9, -1, rb);
      err_clr = 1'b1;
      end_frame(cnt, val, saw_err);
      err_clr = 1'b0;
      idle(2);
      check("ovr_err_seen",  saw_err,   1'b1);
      check("ovr_strobe_n",  cnt,       0);
      check("ovr_rx_data",   rx_data,   16'h00A5);
      check("ovr_err_after", frame_err, 1'b0);

      // sel and tx_data change mid-frame after bit 3
      tx_data[7:0] = 8'h11;
      do_frame(1'b0, {8'h5A, 1'b0}, 8, 3, rb);
      end_frame(cnt, val, saw_err);
      check("mid_readback",  rb,        8'h11);
      check("mid_rx_data",   rx_data,   16'h005A);
      check("mid_strobe_n",  cnt,       1);
      check("mid_strobe_ch", val,       2'b01);
      rpi_sel = 1'b0;
      idle(4);

      // Reset mid-frame, released with le still low
      do_frame(1'b0, {8'hF0, 1'b0}, 4, -1, rb);
      rst_n = 1'b0;
      idle(2);
      check("rstmid_sdout", rpi_sdout, 1'b0);
      rst_n = 1'b1;
      idle(8);
      end_frame(cnt, val, saw_err);
      check("rstmid_strobe_n", cnt,       0);
      check("rstmid_err_seen", saw_err,   1'b0);
      check("rstmid_rx_data",  rx_data,   16'h0000);
      check("rstmid_err",      frame_err, 1'b0);

      // Normal frame after the abandoned one
      do_frame(1'b1, {8'hC3, 1'b0}, 8, -1, rb);
      end_frame(cnt, val, saw_err);
      check("post_rx_data",   rx_data, 16'hC300);
      check("post_strobe_n",  cnt,     1);
      check("post_strobe_ch", val,     2'b10);
      check("post_readback",  rb,      8'h3C);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
